// File: rtl/shifter_arbiter_pkg.sv
// Shared widths, direction encodings and helpers for the two-requester shift arbiter.
package shifter_arbiter_pkg;

  localparam int unsigned DATA_W  = 32;
  localparam int unsigned SHAMT_W = 5;

  localparam logic DIR_LEFT  = 1'b1;
  localparam logic DIR_RIGHT = 1'b0;

  typedef struct packed {
    logic [DATA_W-1:0]  data;
    logic               dir;
    logic [SHAMT_W-1:0] shamt;
  } shift_op_t;

  function automatic logic [DATA_W-1:0] bit_reverse(input logic [DATA_W-1:0] d);
    logic [DATA_W-1:0] r;
    for (int i = 0; i < DATA_W; i++) begin
      r[i] = d[DATA_W-1-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/shifter.sv
// Combinational logical shifter, zero fill. Left shifts reuse the right-shift barrel
// by mirroring the operand on the way in and the result on the way out.
module shifter
  import shifter_arbiter_pkg::*;
(
  input  logic [DATA_W-1:0]  i_data,
  input  logic               i_dir,
  input  logic [SHAMT_W-1:0] i_shamt,
  output logic [DATA_W-1:0]  o_data
);

  logic [DATA_W-1:0] w_shr;

  always_comb begin
    logic [DATA_W-1:0] v;
    v = (i_dir == DIR_RIGHT) ? i_data : bit_reverse(i_data);
    for (int s = 0; s < SHAMT_W; s++) begin
      if (i_shamt[s]) begin
        v = v >> (1 << s);
      end
    end
    w_shr = v;
  end

  assign o_data = (i_dir == DIR_LEFT) ? bit_reverse(w_shr) : w_shr;

endmodule

// File: rtl/shifter_arbiter.sv
// Two-requester round-robin front end for one shared shifter with a single registered
// result slot and per-requester saturating grant counters.
module shifter_arbiter
  import shifter_arbiter_pkg::*;
#(
  parameter int unsigned RESET_PRIO = 0,
  parameter int unsigned CNT_W      = 16
) (
  input  logic               clk,
  input  logic               rst,

  input  logic               req0_valid,
  output logic               req0_ready,
  input  logic [DATA_W-1:0]  req0_data,
  input  logic               req0_dir,
  input  logic [SHAMT_W-1:0] req0_shamt,

  input  logic               req1_valid,
  output logic               req1_ready,
  input  logic [DATA_W-1:0]  req1_data,
  input  logic               req1_dir,
  input  logic [SHAMT_W-1:0] req1_shamt,

  output logic               resp_valid,
  input  logic               resp_ready,
  output logic [DATA_W-1:0]  resp_data,
  output logic               resp_id,

  output logic [CNT_W-1:0]   grant_cnt0,
  output logic [CNT_W-1:0]   grant_cnt1
);

  logic              r_resp_valid;
  logic [DATA_W-1:0] r_resp_data;
  logic              r_resp_id;
  logic              r_prio;
  logic [CNT_W-1:0]  r_cnt0;
  logic [CNT_W-1:0]  r_cnt1;

  logic              w_can_accept;
  logic              w_grant_vld;
  logic              w_grant;
  logic              w_accept;
  shift_op_t         w_op;
  logic [DATA_W-1:0] w_shifted;

  assign w_can_accept = !r_resp_valid || resp_ready;
  assign w_grant_vld  = req0_valid || req1_valid;
  // Contention resolves by prio; otherwise the lone valid requester wins.
  assign w_grant      = (req0_valid && req1_valid) ? r_prio : req1_valid;
  assign w_accept     = !rst && w_can_accept && w_grant_vld;

  assign req0_ready = w_accept && !w_grant;
  assign req1_ready = w_accept && w_grant;

  always_comb begin
    if (w_grant) begin
      w_op = '{data: req1_data, dir: req1_dir, shamt: req1_shamt};
    end else begin
      w_op = '{data: req0_data, dir: req0_dir, shamt: req0_shamt};
    end
  end

  shifter u_shifter (
    .i_data  (w_op.data),
    .i_dir   (w_op.dir),
    .i_shamt (w_op.shamt),
    .o_data  (w_shifted)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_resp_valid <= 1'b0;
      r_resp_data  <= '0;
      r_resp_id    <= 1'b0;
      r_prio       <= 1'(RESET_PRIO);
      r_cnt0       <= '0;
      r_cnt1       <= '0;
    end else if (w_accept) begin
      r_resp_valid <= 1'b1;
      r_resp_data  <= w_shifted;
      r_resp_id    <= w_grant;
      r_prio       <= !w_grant;
      if (!w_grant && (r_cnt0 != '1)) begin
        r_cnt0 <= r_cnt0 + CNT_W'(1);
      end
      if (w_grant && (r_cnt1 != '1)) begin
        r_cnt1 <= r_cnt1 + CNT_W'(1);
      end
    end else if (resp_ready) begin
      r_resp_valid <= 1'b0;
    end
  end

  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_id    = r_resp_id;
  assign grant_cnt0 = r_cnt0;
  assign grant_cnt1 = r_cnt1;

endmodule

// File: tb/tb_shifter_arbiter.sv
// Directed bench for shifter_arbiter: a transaction-level model checked every cycle,
// plus literal expectations at the points of interest.
module tb_shifter_arbiter;

  localparam int unsigned CW   = 4;
  localparam int          MAXC = (1 << CW) - 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req1_valid;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_data, req1_data;
  logic        req0_dir, req1_dir;
  logic [4:0]  req0_shamt, req1_shamt;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_data;
  logic        resp_id;
  logic [CW-1:0] grant_cnt0, grant_cnt1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  shifter_arbiter #(
    .RESET_PRIO (0),
    .CNT_W      (CW)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_data  (req0_data),
    .req0_dir   (req0_dir),
    .req0_shamt (req0_shamt),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_data  (req1_data),
    .req1_dir   (req1_dir),
    .req1_shamt (req1_shamt),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_id    (resp_id),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  logic        m_live = 1'b0;
  logic        m_valid;
  logic [31:0] m_data;
  logic        m_id;
  logic        m_prio;
  int          m_cnt0, m_cnt1;
  logic        exp_r0, exp_r1;

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic dir,
                                            input logic [4:0] sh);
    return dir ? (d << sh) : (d >> sh);
  endfunction

  always_comb begin
    exp_r0 = 1'b0;
    exp_r1 = 1'b0;
    if (m_live && !rst && (!m_valid || resp_ready)) begin
      if (req0_valid && req1_valid) begin
        if (m_prio) exp_r1 = 1'b1;
        else        exp_r0 = 1'b1;
      end else if (req0_valid) begin
        exp_r0 = 1'b1;
      end else if (req1_valid) begin
        exp_r1 = 1'b1;
      end
    end
  end

  always @(posedge clk) begin
    m_live <= 1'b1;
    if (rst) begin
      m_valid <= 1'b0;
      m_data  <= '0;
      m_id    <= 1'b0;
      m_prio  <= 1'b0;
      m_cnt0  <= 0;
      m_cnt1  <= 0;
    end else if (exp_r0) begin
      m_valid <= 1'b1;
      m_data  <= ref_shift(req0_data, req0_dir, req0_shamt);
      m_id    <= 1'b0;
      m_prio  <= 1'b1;
      m_cnt0  <= (m_cnt0 >= MAXC) ? MAXC : m_cnt0 + 1;
    end else if (exp_r1) begin
      m_valid <= 1'b1;
      m_data  <= ref_shift(req1_data, req1_dir, req1_shamt);
      m_id    <= 1'b1;
      m_prio  <= 1'b0;
      m_cnt1  <= (m_cnt1 >= MAXC) ? MAXC : m_cnt1 + 1;
    end else if (resp_ready) begin
      m_valid <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (m_live) begin
      check("model_req0_ready", 32'(req0_ready), 32'(exp_r0));
      check("model_req1_ready", 32'(req1_ready), 32'(exp_r1));
      check("model_resp_valid", 32'(resp_valid), 32'(m_valid));
      if (m_valid) begin
        check("model_resp_data", resp_data, m_data);
        check("model_resp_id", 32'(resp_id), 32'(m_id));
      end
      check("model_cnt0", 32'(grant_cnt0), m_cnt0);
      check("model_cnt1", 32'(grant_cnt1), m_cnt1);
    end
  end

  // ---------------- stimulus ----------------
  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic sample;
    @(negedge clk);
    #1;
  endtask

  task automatic do_op(input string name, input logic id, input logic [31:0] d,
                       input logic dir, input logic [4:0] sh, input logic [31:0] exp);
    int n;
    step;
    resp_ready = 1'b1;
    if (id) begin
      req1_valid = 1'b1; req1_data = d; req1_dir = dir; req1_shamt = sh;
    end else begin
      req0_valid = 1'b1; req0_data = d; req0_dir = dir; req0_shamt = sh;
    end
    n = 0;
    sample;
    while (!(id ? req1_ready : req0_ready) && n < 10) begin
      step;
      sample;
      n++;
    end
    check({name, "_ready"}, 32'(id ? req1_ready : req0_ready), 32'd1);
    step;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    sample;
    check({name, "_data"}, resp_data, exp);
    check({name, "_id"}, 32'(resp_id), 32'(id));
  endtask

  initial begin
    rst = 1'b1;
    req0_valid = 1'b0; req0_data = '0; req0_dir = 1'b0; req0_shamt = '0;
    req1_valid = 1'b0; req1_data = '0; req1_dir = 1'b0; req1_shamt = '0;
    resp_ready = 1'b1;

    // Reset values; a valid request during reset must not be readied
    step;
    req0_valid = 1'b1;
    step;
    sample;
    check("rst_resp_valid", 32'(resp_valid), 32'd0);
    check("rst_resp_data", resp_data, 32'd0);
    check("rst_resp_id", 32'(resp_id), 32'd0);
    check("rst_cnt0", 32'(grant_cnt0), 32'd0);
    check("rst_cnt1", 32'(grant_cnt1), 32'd0);
    check("rst_req0_ready", 32'(req0_ready), 32'd0);

    // Single request
    step;
    rst = 1'b0;
    req0_valid = 1'b1; req0_data = 32'h0000_00F0; req0_dir = 1'b1; req0_shamt = 5'd4;
    sample;
    check("single_req0_ready", 32'(req0_ready), 32'd1);
    step;
    req0_valid = 1'b0;
    sample;
    check("single_resp_valid", 32'(resp_valid), 32'd1);
    check("single_resp_data", resp_data, 32'h0000_0F00);
    check("single_resp_id", 32'(resp_id), 32'd0);

    // Contention after reset: 0,1,0,1 back-to-back
    step;
    rst = 1'b1;
    step;
    rst = 1'b0;
    req0_valid = 1'b1; req0_data = 32'h1;   req0_dir = 1'b1; req0_shamt = 5'd1;
    req1_valid = 1'b1; req1_data = 32'h100; req1_dir = 1'b0; req1_shamt = 5'd4;
    for (int k = 0; k < 4; k++) begin
      sample;
      check("cont_req0_ready", 32'(req0_ready), 32'((k % 2) == 0));
      check("cont_req1_ready", 32'(req1_ready), 32'((k % 2) == 1));
      if (k > 0) begin
        check("cont_resp_valid", 32'(resp_valid), 32'd1);
        check("cont_resp_data", resp_data, (k % 2 == 1) ? 32'h2 : 32'h10);
      end
      step;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    resp_ready = 1'b0;
    sample;
    check("cont_cnt0", 32'(grant_cnt0), 32'd2);
    check("cont_cnt1", 32'(grant_cnt1), 32'd2);
    check("cont_last_data", resp_data, 32'h10);
    check("cont_last_id", 32'(resp_id), 32'd1);

    // Backpressure for 3 cycles, then accept in the release cycle
    step;
    req0_valid = 1'b1; req0_data = 32'h1234; req0_dir = 1'b1; req0_shamt = 5'd8;
    for (int k = 0; k < 3; k++) begin
      sample;
      check("bp_req0_ready", 32'(req0_ready), 32'd0);
      check("bp_req1_ready", 32'(req1_ready), 32'd0);
      check("bp_resp_data", resp_data, 32'h10);
      check("bp_resp_id", 32'(resp_id), 32'd1);
      step;
    end
    resp_ready = 1'b1;
    sample;
    check("bp_release_ready", 32'(req0_ready), 32'd1);
    step;
    req0_valid = 1'b0;
    sample;
    check("bp_release_data", resp_data, 32'h0012_3400);

    // Boundaries
    do_op("bnd_right31", 1'b0, 32'h8000_0001, 1'b0, 5'd31, 32'h0000_0001);
    do_op("bnd_left31", 1'b1, 32'h8000_0001, 1'b1, 5'd31, 32'h8000_0000);
    do_op("bnd_zero_r", 1'b0, 32'hDEAD_BEEF, 1'b0, 5'd0, 32'hDEAD_BEEF);
    do_op("bnd_zero_l", 1'b1, 32'hDEAD_BEEF, 1'b1, 5'd0, 32'hDEAD_BEEF);

    // Reset with a held result in flight
    step;
    resp_ready = 1'b0;
    req0_valid = 1'b1; req0_data = 32'h5; req0_dir = 1'b1; req0_shamt = 5'd0;
    sample;
    step;
    req0_valid = 1'b0;
    sample;
    check("mid_held_valid", 32'(resp_valid), 32'd1);
    step;
    rst = 1'b1;
    sample;
    check("mid_rst_ready0", 32'(req0_ready), 32'd0);
    step;
    rst = 1'b0;
    resp_ready = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    sample;
    check("mid_resp_valid", 32'(resp_valid), 32'd0);
    check("mid_cnt0", 32'(grant_cnt0), 32'd0);
    check("mid_cnt1", 32'(grant_cnt1), 32'd0);
    check("mid_prio_req0", 32'(req0_ready), 32'd1);
    step;
    req0_valid = 1'b0;

    // Saturation: 20 req1 acceptances on a 4-bit counter
    req1_data = 32'hF; req1_dir = 1'b0; req1_shamt = 5'd1;
    repeat (20) step;
    req1_valid = 1'b0;
    sample;
    check("sat_cnt1", 32'(grant_cnt1), 32'd15);
    check("sat_cnt0", 32'(grant_cnt0), 32'd1);

    repeat (3) step;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1);
  end

endmodule
